// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

    typedef enum logic {
        RUN,
        DRAIN
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fifo_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO holding returned words with their PCs
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  fifo_entry_t         push_data,
    input  logic                pop,
    input  logic                flush,
    output fifo_entry_t         head,
    output logic [DEPTH_LOG2:0] count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    fifo_entry_t           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && !flush && ((count_q != CW'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count = count_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - fetch PC, credit-limited imem reads, redirect squash (IFU_MISALIGN_FAULT_EN adds misaligned-target fault)
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN       = fetch_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = fetch_pkg::RESET_PC_DEFAULT,
    parameter int              DEPTH_LOG2 = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc
`ifdef IFU_MISALIGN_FAULT_EN
    ,
    output logic            fetch_fault,
    output logic [XLEN-1:0] fault_pc
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] ret_pc_q, ret_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic            imem_req_q, imem_req_d;
    logic            fetch_blocked_d;
    logic [XLEN-1:0] fetch_target;

    logic            gnt_fire;
    logic            fifo_push, fifo_pop, fifo_flush;
    fifo_entry_t     push_entry, head_entry;
    logic [CW-1:0]   fifo_count, count_next;
    logic [CW:0]     inflight_next;

`ifdef IFU_MISALIGN_FAULT_EN
    logic            fault_q, fault_d;
    logic [XLEN-1:0] fault_pc_q, fault_pc_d;
    assign fetch_fault  = fault_q;
    assign fault_pc     = fault_pc_q;
    assign fetch_target = redirect_pc;
`else
    assign fetch_target = word_align(redirect_pc);
`endif

    assign gnt_fire   = imem_req_q && imem_gnt;
    assign inst_valid = (fifo_count != '0);
    assign fifo_pop   = inst_valid && inst_ready;
    assign push_entry = '{inst: imem_rdata, pc: ret_pc_q};

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ret_pc_d      = ret_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        fifo_push     = 1'b0;
        fifo_flush    = 1'b0;
`ifdef IFU_MISALIGN_FAULT_EN
        fault_d       = fault_q;
        fault_pc_d    = fault_pc_q;
`endif

        if (gnt_fire) begin
            pc_d          = pc_q + XLEN'(4);
            outstanding_d = outstanding_d + CW'(1);
        end
        if (imem_rvalid) outstanding_d = outstanding_d - CW'(1);

        // Every request still in flight after a redirect is wrong-path, so the
        // discard count is simply the post-update outstanding count.
        if (redirect) begin
            fifo_flush = 1'b1;
            pc_d       = fetch_target;
            ret_pc_d   = fetch_target;
            discard_d  = outstanding_d;
            state_d    = (outstanding_d != '0) ? DRAIN : RUN;
`ifdef IFU_MISALIGN_FAULT_EN
            fault_d = (redirect_pc[1:0] != 2'b00);
            if (redirect_pc[1:0] != 2'b00) fault_pc_d = redirect_pc;
`endif
        end else if (imem_rvalid) begin
            if (state_q == RUN) begin
                fifo_push = 1'b1;
                ret_pc_d  = ret_pc_q + XLEN'(4);
            end else begin
                discard_d = discard_q - CW'(1);
                if (discard_d == '0) state_d = RUN;
            end
        end

`ifdef IFU_MISALIGN_FAULT_EN
        fetch_blocked_d = fault_d;
`else
        fetch_blocked_d = 1'b0;
`endif
        count_next    = fifo_flush ? '0 : fifo_count + CW'(fifo_push) - CW'(fifo_pop);
        inflight_next = {1'b0, count_next} + {1'b0, outstanding_d};
        imem_req_d    = (state_d == RUN) && !fetch_blocked_d && (inflight_next < (CW + 1)'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            ret_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            imem_req_q    <= 1'b0;
`ifdef IFU_MISALIGN_FAULT_EN
            fault_q       <= 1'b0;
            fault_pc_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ret_pc_q      <= ret_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            imem_req_q    <= imem_req_d;
`ifdef IFU_MISALIGN_FAULT_EN
            fault_q       <= fault_d;
            fault_pc_q    <= fault_pc_d;
`endif
        end
    end

    fetch_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .head      (head_entry),
        .count     (fifo_count)
    );

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign inst      = head_entry.inst;
    assign inst_pc   = head_entry.pc;

endmodule
